uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_fifo.sv | 58 +++++
 rtl/uart_tx_buffer.sv | 101 ++++++++++
 tb/tb_uart_tx_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit buffer.
package uart_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } buf_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmit path; pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    // A push while full is dropped even if a pop happens in the same cycle.
    assign w_do_push = i_push && !w_full;
    assign w_do_pop  = i_pop && !w_empty;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit buffer: queues host bytes and hands them one at a time to the
// UART TX FSM using a Data_Valid pulse and the busy handshake.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     busy,
    input  logic                     clr_ovf,
    output logic                     Data_Valid,
    output logic [WIDTH-1:0]         P_DATA,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [1:0]               o_dbg_state
);

    buf_state_t       r_state;
    buf_state_t       w_next_state;
    logic             w_pop;
    logic             w_load;
    logic [WIDTH-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] r_p_data;
    logic             r_overflow;

    uart_tx_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (CLK),
        .i_rst_n (RST),
        .i_push  (wr_en),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= ST_IDLE;
        else      r_state <= w_next_state;
    end

    // Handshake: Data_Valid is a one-cycle request with P_DATA already
    // stable; the TX FSM answers by raising busy for the whole frame, and
    // the next request waits until busy has dropped again.
    always_comb begin
        w_next_state = ST_IDLE;
        Data_Valid   = 1'b0;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !busy) begin
                    w_next_state = ST_LOAD;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_LOAD: begin
                Data_Valid   = 1'b1;
                w_pop        = 1'b1;
                w_next_state = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: w_next_state = busy ? ST_WAIT_DONE : ST_WAIT_BUSY;
            ST_WAIT_DONE: w_next_state = busy ? ST_WAIT_DONE : ST_IDLE;
            default:      w_next_state = ST_IDLE;
        endcase
    end

    // The head is captured on entry to LOAD so P_DATA is valid alongside
    // Data_Valid; the head cannot change before the pop at the end of LOAD.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)        r_p_data <= '0;
        else if (w_load) r_p_data <= w_head;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                r_overflow <= 1'b0;
        else if (wr_en && w_full) r_overflow <= 1'b1;
        else if (clr_ovf)         r_overflow <= 1'b0;
    end

    assign P_DATA      = r_p_data;
    assign full        = w_full;
    assign empty       = w_empty;
    assign overflow    = r_overflow;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: directed vector table plus a cycle monitor with
// a scoreboard queue and a simple model of the TX FSM busy response.
module tb_uart_tx_buffer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int NROWS = 24;

    logic             CLK;
    logic             RST;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             clr_ovf;
    logic             Data_Valid;
    logic [WIDTH-1:0] P_DATA;
    logic             full;
    logic             empty;
    logic [3:0]       count;
    logic             overflow;
    logic [1:0]       o_dbg_state;

    logic man_busy;
    logic model_en;
    logic model_busy;
    assign busy = model_en ? model_busy : man_busy;

    uart_tx_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .busy        (busy),
        .clr_ovf     (clr_ovf),
        .Data_Valid  (Data_Valid),
        .P_DATA      (P_DATA),
        .full        (full),
        .empty       (empty),
        .count       (count),
        .overflow    (overflow),
        .o_dbg_state (o_dbg_state)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       bsy;
        logic       clr;
        logic       dv;
        logic [7:0] pd;
        logic       fl;
        logic       em;
        logic [3:0] cnt;
        logic       ov;
        logic [1:0] st;
    } vec_t;

    vec_t vecs [NROWS];

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard and busy-model state, updated only by monitor_sample
    logic [WIDTH-1:0] exp_q[$];
    int dv_cyc_q[$];
    int sb_count  = 0;
    int cyc       = 0;
    int busy_left = 0;
    int fall_cyc  = 0;
    int dv_total  = 0;
    logic fall_live = 1'b0;
    logic prev_dv   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic monitor_sample();
        logic             push;
        logic             pop;
        logic [WIDTH-1:0] exp_v;
        cyc++;
        if (model_en) begin
            if (busy_left > 0) begin
                model_busy = 1'b1;
                busy_left--;
            end else begin
                if (model_busy) begin
                    fall_cyc  = cyc;
                    fall_live = (sb_count > 0);
                end
                model_busy = 1'b0;
            end
        end else begin
            model_busy = 1'b0;
            busy_left  = 0;
            fall_live  = 1'b0;
        end
        if (!RST) begin
            exp_q.delete();
            sb_count = 0;
            prev_dv  = 1'b0;
            fall_live = 1'b0;
            return;
        end
        check("mon_count", count, sb_count);
        check("mon_empty", empty, (sb_count == 0));
        check("mon_full", full, (sb_count == DEPTH));
        pop = 1'b0;
        if (Data_Valid) begin
            check("dv_one_cycle", prev_dv, 0);
            if (exp_q.size() == 0) begin
                check("dv_unexpected", Data_Valid, 0);
            end else begin
                exp_v = exp_q.pop_front();
                check("p_data_order", P_DATA, exp_v);
                pop = 1'b1;
            end
            if (fall_live) check("busy_fall_to_dv", cyc - fall_cyc, 2);
            fall_live = 1'b0;
            dv_total++;
            dv_cyc_q.push_back(cyc);
            if (model_en) busy_left = 11;
        end
        prev_dv = Data_Valid;
        push = wr_en && (sb_count < DEPTH);
        if (push) exp_q.push_back(wr_data);
        sb_count = sb_count + (push ? 1 : 0) - (pop ? 1 : 0);
    endtask

    // One clock: sample at the falling edge, return just after the rising edge.
    task automatic step();
        @(negedge CLK);
        monitor_sample();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_row(input int i, input logic we, input logic [7:0] wd,
                           input logic bsy, input logic clr, input logic dv,
                           input logic [7:0] pd, input logic fl, input logic em,
                           input logic [3:0] cnt, input logic ov, input logic [1:0] st);
        vecs[i].we = we;  vecs[i].wd = wd;  vecs[i].bsy = bsy; vecs[i].clr = clr;
        vecs[i].dv = dv;  vecs[i].pd = pd;  vecs[i].fl = fl;   vecs[i].em = em;
        vecs[i].cnt = cnt; vecs[i].ov = ov; vecs[i].st = st;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            wr_en    = vecs[i].we;
            wr_data  = vecs[i].wd;
            man_busy = vecs[i].bsy;
            clr_ovf  = vecs[i].clr;
            step();
            check($sformatf("row%0d_dv", i), Data_Valid, vecs[i].dv);
            check($sformatf("row%0d_pdata", i), P_DATA, vecs[i].pd);
            check($sformatf("row%0d_full", i), full, vecs[i].fl);
            check($sformatf("row%0d_empty", i), empty, vecs[i].em);
            check($sformatf("row%0d_count", i), count, vecs[i].cnt);
            check($sformatf("row%0d_ovf", i), overflow, vecs[i].ov);
            check($sformatf("row%0d_state", i), o_dbg_state, vecs[i].st);
        end
        wr_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (!(exp_q.size() == 0 && busy_left == 0 && !model_busy) && n < limit) begin
            step();
            n++;
        end
        check(name, (n < limit), 1);
        repeat (3) step();
    endtask

    initial begin
        int base;
        int cbase;
        int w_cyc;
        int guard;

        // write 0xA5 into an idle buffer
        set_row(0, 1, 8'hA5, 0, 0, 0, 8'h00, 0, 0, 4'd1, 0, 2'd0);
        set_row(1, 0, 8'h00, 0, 0, 1, 8'hA5, 0, 0, 4'd1, 0, 2'd1);
        set_row(2, 0, 8'h00, 0, 0, 0, 8'hA5, 0, 1, 4'd0, 0, 2'd2);
        set_row(3, 0, 8'h00, 1, 0, 0, 8'hA5, 0, 1, 4'd0, 0, 2'd3);
        set_row(4, 0, 8'h00, 0, 0, 0, 8'hA5, 0, 1, 4'd0, 0, 2'd0);
        set_row(5, 0, 8'h00, 0, 0, 0, 8'hA5, 0, 1, 4'd0, 0, 2'd0);
        // fill to full with busy held high, then overflow and clear
        for (int k = 1; k <= 8; k++)
            set_row(5 + k, 1, 8'(k), 1, 0, 0, 8'hA5, (k == 8), 0, 4'(k), 0, 2'd0);
        set_row(14, 1, 8'h09, 1, 0, 0, 8'hA5, 1, 0, 4'd8, 1, 2'd0);
        set_row(15, 0, 8'h00, 1, 1, 0, 8'hA5, 1, 0, 4'd8, 0, 2'd0);
        set_row(16, 1, 8'h0A, 1, 1, 0, 8'hA5, 1, 0, 4'd8, 1, 2'd0);
        set_row(17, 0, 8'h00, 1, 0, 0, 8'hA5, 1, 0, 4'd8, 1, 2'd0);
        set_row(18, 0, 8'h00, 1, 1, 0, 8'hA5, 1, 0, 4'd8, 0, 2'd0);
        // fresh write after a mid-frame reset
        set_row(19, 1, 8'h5A, 0, 0, 0, 8'h00, 0, 0, 4'd1, 0, 2'd0);
        set_row(20, 0, 8'h00, 0, 0, 1, 8'h5A, 0, 0, 4'd1, 0, 2'd1);
        set_row(21, 0, 8'h00, 0, 0, 0, 8'h5A, 0, 1, 4'd0, 0, 2'd2);
        set_row(22, 0, 8'h00, 1, 0, 0, 8'h5A, 0, 1, 4'd0, 0, 2'd3);
        set_row(23, 0, 8'h00, 0, 0, 0, 8'h5A, 0, 1, 4'd0, 0, 2'd0);

        RST = 1'b0; wr_en = 1'b0; wr_data = '0; clr_ovf = 1'b0;
        man_busy = 1'b0; model_en = 1'b0; model_busy = 1'b0;
        repeat (3) step();
        check("rst_dv", Data_Valid, 0);
        check("rst_pdata", P_DATA, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", o_dbg_state, 0);
        RST = 1'b1;
        step();

        run_rows(0, 18);

        // drain the eight queued bytes through the busy model
        base = dv_total;
        man_busy = 1'b0;
        model_en = 1'b1;
        wait_drain("drain_full_timeout", 400);
        check("drain_full_dv_count", dv_total - base, 8);

        // three back-to-back bytes
        base  = dv_total;
        cbase = dv_cyc_q.size();
        wr_en = 1'b1; wr_data = 8'h11; step();
        w_cyc = cyc;
        wr_data = 8'h22; step();
        wr_data = 8'h33; step();
        wr_en = 1'b0;
        wait_drain("burst3_timeout", 200);
        check("burst3_dv_count", dv_total - base, 3);
        check("burst3_first_latency", dv_cyc_q[cbase] - w_cyc, 2);

        // more than 2*DEPTH writes interleaved with reads: pointer wrap
        base = dv_total;
        for (int i = 0; i < 20; i++) begin
            guard = 0;
            while (sb_count >= DEPTH && guard < 200) begin
                step();
                guard++;
            end
            check($sformatf("wrap_space%0d", i), (guard < 200), 1);
            wr_en = 1'b1;
            wr_data = 8'(i * 29 + 3);
            step();
            wr_en = 1'b0;
            repeat ((i * 5) % 7) step();
        end
        wait_drain("wrap_timeout", 600);
        check("wrap_dv_count", dv_total - base, 20);

        // reset during WAIT_DONE with four bytes still queued
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(8'hC0 + i);
            step();
        end
        wr_en = 1'b0;
        guard = 0;
        while (!(model_busy && busy_left <= 8) && guard < 50) begin
            step();
            guard++;
        end
        check("pre_reset_reached", (guard < 50), 1);
        check("pre_reset_state", o_dbg_state, 3);
        check("pre_reset_count", count, 4);
        model_en = 1'b0;
        man_busy = 1'b1;
        #2 RST = 1'b0;
        #1;
        check("midrst_empty", empty, 1);
        check("midrst_count", count, 0);
        check("midrst_dv", Data_Valid, 0);
        check("midrst_full", full, 0);
        check("midrst_pdata", P_DATA, 0);
        check("midrst_state", o_dbg_state, 0);
        repeat (2) step();
        RST = 1'b1;
        man_busy = 1'b0;
        base = dv_total;
        repeat (10) step();
        check("post_reset_no_tx", dv_total - base, 0);
        check("post_reset_empty", empty, 1);
        run_rows(19, 23);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard time limit in case a wait above is ever left unbounded.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
